// File: rtl/eth_pkg.sv
// Shared constants, FSM state type and the byte-wise CRC32 step for the GMII RX front end.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE  = 32'hC704_DD7B;
    localparam logic [31:0] CRC_POLY     = 32'h04C1_1DB7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRE,
        ST_DATA,
        ST_DROP
    } rx_state_t;

    // Non-reflected register, data bits fed LSB first (Ethernet bit order).
    function automatic logic [31:0] crc32_d8_next(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        logic        fb;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            fb = c[31] ^ data[i];
            c  = {c[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_rx_dly5.sv
// Five-entry byte shift line holding the FCS look-ahead; taps[4] is the oldest byte once full.
module eth_rx_dly5 (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            shift,
    input  logic [7:0]      din,
    output logic [4:0][7:0] taps,
    output logic            full
);

    logic [2:0] fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps <= '0;
            fill <= '0;
        end else if (clr) begin
            taps <= '0;
            fill <= '0;
        end else if (shift) begin
            taps <= {taps[3:0], din};
            if (fill != 3'd5) begin
                fill <= fill + 3'd1;
            end
        end
    end

    assign full = (fill == 3'd5);

endmodule

// File: rtl/eth_rx_fcs_check.sv
// GMII RX front end: strips preamble/SFD, checks FCS, forwards payload without the FCS bytes.
// Optional destination-MAC filter enabled by defining ETH_RX_DEST_FILTER_EN.
module eth_rx_fcs_check
    import eth_pkg::*;
#(
    parameter int unsigned MAX_LEN   = 1514,
    parameter logic [47:0] LOCAL_MAC = 48'h00_11_22_33_44_55
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    input  logic [7:0]  gmii_rxd,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_done,
    output logic        rx_crc_ok,
    output logic        rx_err,
    output logic [15:0] rx_len
);

    rx_state_t       state, state_nxt;
    logic [31:0]     crc_q, crc_nxt;
    logic            er_q, er_nxt;
    logic            abort_q, abort_nxt;
    logic [15:0]     len_q, len_nxt;
    logic            line_clr, line_shift, line_full;
    logic [4:0][7:0] taps;
    logic            emit_due, over_len, dest_ok, dest_miss;

    logic [7:0]      data_nxt;
    logic            valid_nxt, sof_nxt, eof_nxt, done_nxt, ok_nxt, err_nxt;
    logic [15:0]     rlen_nxt;

    eth_rx_dly5 u_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (line_clr),
        .shift (line_shift),
        .din   (gmii_rxd),
        .taps  (taps),
        .full  (line_full)
    );

    assign emit_due = (state == ST_DATA) && gmii_rx_dv && line_full;
    assign over_len = (len_q >= 16'(MAX_LEN));

`ifdef ETH_RX_DEST_FILTER_EN
    logic [47:0] dest;
    assign dest    = {taps[4], taps[3], taps[2], taps[1], taps[0], gmii_rxd};
    assign dest_ok = (dest == LOCAL_MAC) || (dest == 48'hFFFF_FFFF_FFFF);
`else
    logic unused_cfg;
    assign unused_cfg = ^{LOCAL_MAC, taps[3:0]};
    assign dest_ok    = 1'b1;
`endif

    // The destination is only fully known when the first payload byte is due out.
    assign dest_miss = emit_due && (len_q == 16'd0) && !dest_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (gmii_rx_dv) begin
                    if (gmii_rxd == ETH_PREAMBLE) state_nxt = ST_PRE;
                    else if (gmii_rxd == ETH_SFD) state_nxt = ST_DATA;
                    else                          state_nxt = ST_DROP;
                end
            end
            ST_PRE: begin
                if (!gmii_rx_dv)                   state_nxt = ST_IDLE;
                else if (gmii_rxd == ETH_PREAMBLE) state_nxt = ST_PRE;
                else if (gmii_rxd == ETH_SFD)      state_nxt = ST_DATA;
                else                               state_nxt = ST_DROP;
            end
            ST_DATA: begin
                if (!gmii_rx_dv)                             state_nxt = ST_IDLE;
                else if (dest_miss || (emit_due && over_len)) state_nxt = ST_DROP;
            end
            ST_DROP: begin
                if (!gmii_rx_dv) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        line_clr   = 1'b0;
        line_shift = 1'b0;
        crc_nxt    = crc_q;
        er_nxt     = er_q;
        abort_nxt  = abort_q;
        len_nxt    = len_q;
        data_nxt   = '0;
        valid_nxt  = 1'b0;
        sof_nxt    = 1'b0;
        eof_nxt    = 1'b0;
        done_nxt   = 1'b0;
        ok_nxt     = 1'b0;
        err_nxt    = 1'b0;
        rlen_nxt   = '0;
        case (state)
            ST_IDLE, ST_PRE: begin
                abort_nxt = 1'b0;
                if (gmii_rx_dv && (gmii_rxd == ETH_SFD)) begin
                    line_clr = 1'b1;
                    crc_nxt  = CRC_INIT;
                    er_nxt   = 1'b0;
                    len_nxt  = '0;
                end
            end
            ST_DATA: begin
                if (gmii_rx_dv) begin
                    line_shift = 1'b1;
                    crc_nxt    = crc32_d8_next(crc_q, gmii_rxd);
                    if (gmii_rx_er) er_nxt = 1'b1;
                    if (emit_due && !dest_miss) begin
                        if (over_len) begin
                            abort_nxt = 1'b1;
                        end else begin
                            valid_nxt = 1'b1;
                            data_nxt  = taps[4];
                            sof_nxt   = (len_q == 16'd0);
                            len_nxt   = len_q + 16'd1;
                        end
                    end
                end else begin
                    // Line now holds last payload byte plus the four FCS bytes.
                    done_nxt = 1'b1;
                    if (!line_full) begin
                        err_nxt = 1'b1;
                    end else if (over_len) begin
                        err_nxt  = 1'b1;
                        rlen_nxt = len_q;
                    end else begin
                        valid_nxt = 1'b1;
                        data_nxt  = taps[4];
                        sof_nxt   = (len_q == 16'd0);
                        eof_nxt   = 1'b1;
                        rlen_nxt  = len_q + 16'd1;
                        err_nxt   = er_q;
                        ok_nxt    = !er_q && (crc_q == CRC_RESIDUE);
                    end
                end
            end
            ST_DROP: begin
                if (!gmii_rx_dv) begin
                    abort_nxt = 1'b0;
                    if (abort_q) begin
                        done_nxt = 1'b1;
                        err_nxt  = 1'b1;
                        rlen_nxt = len_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q   <= CRC_INIT;
            er_q    <= 1'b0;
            abort_q <= 1'b0;
            len_q   <= '0;
        end else begin
            crc_q   <= crc_nxt;
            er_q    <= er_nxt;
            abort_q <= abort_nxt;
            len_q   <= len_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_sof    <= 1'b0;
            rx_eof    <= 1'b0;
            rx_done   <= 1'b0;
            rx_crc_ok <= 1'b0;
            rx_err    <= 1'b0;
            rx_len    <= '0;
        end else begin
            rx_data   <= data_nxt;
            rx_valid  <= valid_nxt;
            rx_sof    <= sof_nxt;
            rx_eof    <= eof_nxt;
            rx_done   <= done_nxt;
            rx_crc_ok <= ok_nxt;
            rx_err    <= err_nxt;
            rx_len    <= rlen_nxt;
        end
    end

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Scoreboard bench for eth_rx_fcs_check: stimulus pushes expected bytes/status, a monitor pops and compares.
module tb_eth_rx_fcs_check;

    localparam int MAX_LEN = 1514;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gmii_rx_dv = 1'b0;
    logic        gmii_rx_er = 1'b0;
    logic [7:0]  gmii_rxd = 8'h00;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_sof, rx_eof, rx_done, rx_crc_ok, rx_err;
    logic [15:0] rx_len;

    int checks = 0;
    int failures = 0;

    typedef struct packed { logic [7:0] data; logic sof; logic eof; } exp_byte_t;
    typedef struct packed { logic ok; logic err; logic [15:0] len; } exp_stat_t;

    exp_byte_t byte_q[$];
    exp_stat_t stat_q[$];
    exp_byte_t mon_b;
    exp_stat_t mon_s;
    logic [7:0] frame [0:1700];

    eth_rx_fcs_check #(.MAX_LEN(MAX_LEN), .LOCAL_MAC(48'h00_11_22_33_44_55)) dut (
        .clk(clk), .rst_n(rst_n), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
        .gmii_rxd(gmii_rxd), .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof),
        .rx_eof(rx_eof), .rx_done(rx_done), .rx_crc_ok(rx_crc_ok), .rx_err(rx_err), .rx_len(rx_len)
    );

    always #4 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                checks++;
                if (byte_q.size() == 0) begin
                    failures++;
                    $display("FAIL byte_unexpected got data=%02h sof=%0b eof=%0b", rx_data, rx_sof, rx_eof);
                end else begin
                    mon_b = byte_q.pop_front();
                    if ({rx_data, rx_sof, rx_eof} !== {mon_b.data, mon_b.sof, mon_b.eof}) begin
                        failures++;
                        $display("FAIL byte got data=%02h sof=%0b eof=%0b want data=%02h sof=%0b eof=%0b",
                                 rx_data, rx_sof, rx_eof, mon_b.data, mon_b.sof, mon_b.eof);
                    end
                end
            end
            if (rx_done) begin
                checks++;
                if (stat_q.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected got ok=%0b err=%0b len=%0d", rx_crc_ok, rx_err, rx_len);
                end else begin
                    mon_s = stat_q.pop_front();
                    if ({rx_crc_ok, rx_err, rx_len} !== {mon_s.ok, mon_s.err, mon_s.len}) begin
                        failures++;
                        $display("FAIL status got ok=%0b err=%0b len=%0d want ok=%0b err=%0b len=%0d",
                                 rx_crc_ok, rx_err, rx_len, mon_s.ok, mon_s.err, mon_s.len);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] crc_refl(input int cnt);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < cnt; i++) begin
            c = c ^ {24'h0, frame[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic load_frame(input logic [47:0] dest, input int n);
        for (int i = 0; i < n; i++) frame[i] = 8'(i * 13 + 5);
        for (int i = 0; i < 6; i++) frame[i] = dest[47 - 8*i -: 8];
        frame[6] = 8'h00; frame[7] = 8'h0A; frame[8] = 8'h35;
        frame[9] = 8'h01; frame[10] = 8'h02; frame[11] = 8'h03;
        frame[12] = 8'h08; frame[13] = 8'h06;
    endtask

    task automatic drive_byte(input logic [7:0] b, input logic er);
        gmii_rx_dv = 1'b1;
        gmii_rxd   = b;
        gmii_rx_er = er;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        gmii_rx_dv = 1'b0;
        gmii_rx_er = 1'b0;
        gmii_rxd   = 8'h00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (byte_q.size() != 0 || stat_q.size() != 0) begin
            failures++;
            $display("FAIL %s pending bytes=%0d status=%0d want 0/0", name, byte_q.size(), stat_q.size());
        end
        byte_q.delete();
        stat_q.delete();
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({rx_data, rx_valid, rx_sof, rx_eof, rx_done, rx_crc_ok, rx_err, rx_len} !== '0) begin
            failures++;
            $display("FAIL %s outputs data=%02h v=%0b sof=%0b eof=%0b done=%0b ok=%0b err=%0b len=%0d want all 0",
                     name, rx_data, rx_valid, rx_sof, rx_eof, rx_done, rx_crc_ok, rx_err, rx_len);
        end
    endtask

    // n bytes after SFD from frame[], optional FCS appended, optional bit-3 flip and rx_er pulse.
    task automatic run_frame(input string name, input int n, input bit add_fcs,
                             input int flip_idx, input int er_idx, input bit fwd);
        logic [31:0] fcs;
        int total, pay, emit;
        bit good;
        total = n;
        if (add_fcs) begin
            fcs = ~crc_refl(n);
            for (int j = 0; j < 4; j++) frame[n + j] = fcs[8*j +: 8];
            total = n + 4;
        end
        if (flip_idx >= 0) frame[flip_idx] = frame[flip_idx] ^ 8'h08;
        good = (crc_refl(total) == 32'hDEBB_20E3);
        if (fwd) begin
            if (total < 5) begin
                stat_q.push_back('{ok: 1'b0, err: 1'b1, len: 16'd0});
            end else begin
                pay  = total - 4;
                emit = (pay > MAX_LEN) ? MAX_LEN : pay;
                for (int i = 0; i < emit; i++)
                    byte_q.push_back('{data: frame[i], sof: (i == 0), eof: (i == pay - 1) && (pay <= MAX_LEN)});
                if (pay > MAX_LEN)
                    stat_q.push_back('{ok: 1'b0, err: 1'b1, len: 16'(MAX_LEN)});
                else
                    stat_q.push_back('{ok: good && (er_idx < 0), err: (er_idx >= 0), len: 16'(pay)});
            end
        end
        repeat (7) drive_byte(8'h55, 1'b0);
        drive_byte(8'hD5, 1'b0);
        for (int i = 0; i < total; i++) drive_byte(frame[i], (i == er_idx));
        idle(12);
        check_drained(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        rst_n = 1'b1;
        idle(3);

        load_frame(48'hFFFF_FFFF_FFFF, 60);
        run_frame("arp_good", 60, 1'b1, -1, -1, 1'b1);

        load_frame(48'hFFFF_FFFF_FFFF, 60);
        run_frame("arp_bitflip", 60, 1'b1, 20, -1, 1'b1);

        load_frame(48'hFFFF_FFFF_FFFF, 3);
        run_frame("runt", 3, 1'b0, -1, -1, 1'b1);

        load_frame(48'hFFFF_FFFF_FFFF, 60);
        run_frame("rx_er", 60, 1'b1, -1, 30, 1'b1);

        load_frame(48'hFFFF_FFFF_FFFF, 1);
        run_frame("one_byte", 1, 1'b1, -1, -1, 1'b1);

        load_frame(48'hFFFF_FFFF_FFFF, 1600);
        run_frame("over_len", 1600, 1'b1, -1, -1, 1'b1);

        load_frame(48'hFFFF_FFFF_FFFF, MAX_LEN);
        run_frame("max_len", MAX_LEN, 1'b1, -1, -1, 1'b1);

`ifdef ETH_RX_DEST_FILTER_EN
        load_frame(48'h00_11_22_33_44_56, 60);
        run_frame("filter_miss", 60, 1'b1, -1, -1, 1'b0);
        load_frame(48'h00_11_22_33_44_55, 60);
        run_frame("filter_local", 60, 1'b1, -1, -1, 1'b1);
`else
        load_frame(48'h00_11_22_33_44_56, 60);
        run_frame("nofilter_other", 60, 1'b1, -1, -1, 1'b1);
`endif
        load_frame(48'hFFFF_FFFF_FFFF, 60);
        run_frame("filter_bcast", 60, 1'b1, -1, -1, 1'b1);

        // Reset in the middle of a frame: 15 bytes already out, rest discarded.
        load_frame(48'hFFFF_FFFF_FFFF, 20);
        for (int i = 0; i < 15; i++) byte_q.push_back('{data: frame[i], sof: (i == 0), eof: 1'b0});
        repeat (7) drive_byte(8'h55, 1'b0);
        drive_byte(8'hD5, 1'b0);
        for (int i = 0; i < 20; i++) drive_byte(frame[i], 1'b0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        gmii_rx_dv = 1'b0;
        #1;
        check_zero("reset_midframe");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        check_zero("after_reset");
        check_drained("reset_flush");

        load_frame(48'hFFFF_FFFF_FFFF, 60);
        run_frame("post_reset_good", 60, 1'b1, -1, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
